// File: rtl/io_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_tx_if
// Brief    : CPU-side IO bundle (IOD/IOE/IOA) plus serial line of io_uart_tx.
// Revision : 1.0
// ============================================================================
interface io_uart_tx_if;
   logic [7:0] tx_data;
   logic [7:0] tx_ctrl;
   logic [7:0] status;
   logic       txd;

   modport master (output tx_data, output tx_ctrl, input status, input txd);
   modport slave  (input tx_data, input tx_ctrl, output status, output txd);
endinterface
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_tx
// Brief    : FIFO-buffered UART transmitter, 8N1; define UART_TX_PARITY_EN
//            for 8E1 (even parity bit between D7 and STOP).
// Revision : 1.0
// ============================================================================
module io_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  wire         clk,
   input  wire         rst_n,
   io_uart_tx_if.slave bus
);

   localparam int AW = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [AW-1:0] c_last_ptr  = AW'(FIFO_DEPTH - 1);
   localparam logic [BW-1:0] c_baud_last = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    c_depth     = 3'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   localparam logic          c_parity_en = 1'b1;
`else
   localparam logic          c_parity_en = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t          r_state;
   logic [BW-1:0]   r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
`ifdef UART_TX_PARITY_EN
   logic            r_par;
`endif
   logic            r_txd;
   logic [7:0]      r_ctrl_q;
   logic [7:0]      r_mem [0:FIFO_DEPTH-1];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [2:0]      r_count;
   logic            r_ovf;
   logic [7:0]      r_status;

   logic [2:0]      w_count_nxt;

   wire w_push      = bus.tx_ctrl[0] ^ r_ctrl_q[0];
   wire w_clr       = bus.tx_ctrl[1] & ~r_ctrl_q[1];
   wire w_baud_end  = (r_baud == c_baud_last);
   wire w_full      = (r_count == c_depth);
   wire w_pop       = (r_state == S_IDLE) && (r_count != 3'd0);
   // A push into a full FIFO still lands when the same edge frees a slot.
   wire w_wr        = w_push && (!w_full || w_pop);
   wire w_ovf_set   = w_push && w_full && !w_pop;
   wire w_ovf_nxt   = w_ovf_set | (r_ovf & ~w_clr);
   wire w_busy_nxt  = (r_state == S_IDLE) ? w_pop
                                          : !((r_state == S_STOP) && w_baud_end);
   wire w_unused_ctrl = ^r_ctrl_q[7:2];

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == c_last_ptr) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr, w_pop})
         2'b10:   w_count_nxt = r_count + 3'd1;
         2'b01:   w_count_nxt = r_count - 3'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= bus.tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl_q <= 8'h00;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 3'd0;
         r_ovf    <= 1'b0;
         r_status <= {c_parity_en, 7'h04};
      end else begin
         r_ctrl_q <= bus.tx_ctrl;
         if (w_wr)
            r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop)
            r_rd_ptr <= f_inc(r_rd_ptr);
         r_count  <= w_count_nxt;
         r_ovf    <= w_ovf_nxt;
         r_status <= {c_parity_en, w_count_nxt, w_ovf_nxt,
                      (w_count_nxt == 3'd0), (w_count_nxt == c_depth), w_busy_nxt};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
         r_txd   <= 1'b1;
      end else begin
         r_baud <= (r_state == S_IDLE || w_baud_end) ? '0 : r_baud + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                  r_par   <= ^r_mem[r_rd_ptr];
`endif
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  r_bit   <= 3'd0;
                  r_txd   <= r_shift[0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_txd   <= r_par;
                     r_state <= S_PARITY;
`else
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_txd   <= r_shift[1];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_baud_end) begin
                  r_txd   <= 1'b1;
                  r_state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (w_baud_end)
                  r_state <= S_IDLE;
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.status = r_status;
   assign bus.txd    = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_uart_tx
// Brief    : Directed self-checking bench for io_uart_tx (CLKS_PER_BIT=4, depth 4).
// Revision : 1.0
// ============================================================================
module tb_io_uart_tx;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int   FB = 11;
   localparam logic PE = 1'b1;
`else
   localparam int   FB = 10;
   localparam logic PE = 1'b0;
`endif
   localparam int         TF     = FB * CPB;
   localparam logic [7:0] ST_RST = {PE, 7'h04};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tog   = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   io_uart_tx_if u_if ();

   io_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic toggle(input logic [7:0] d);
      u_if.tx_data    = d;
      tog             = ~tog;
      u_if.tx_ctrl[0] = tog;
   endtask

   // Expected TXD waveform, one bit per clock, starting at the first START cycle.
   function automatic logic [63:0] exp_wave(input logic [7:0] d);
      logic [63:0] w;
      int          j;
      w = '1;
      for (int k = 0; k < TF; k++) begin
         j = k / CPB;
         if (j == 0)                 w[k] = 1'b0;
         else if (j <= 8)            w[k] = d[j-1];
         else if (PE && j == 9)      w[k] = ^d;
         else                        w[k] = 1'b1;
      end
      return w;
   endfunction

   task automatic capture(input logic [7:0] d, input string tag);
      logic [63:0] w;
      int          busy;
      w    = '1;
      busy = 0;
      for (int k = 0; k < TF; k++) begin
         w[k] = u_if.txd;
         if (u_if.status[0] === 1'b1) busy++;
         tick();
      end
      check({tag, "_wave"}, w, exp_wave(d));
      check({tag, "_busy"}, 64'(busy), 64'(TF));
   endtask

   task automatic quiet(input int n, output int bad);
      bad = 0;
      for (int k = 0; k < n; k++) begin
         if (u_if.txd !== 1'b1 || u_if.status !== ST_RST) bad++;
         tick();
      end
   endtask

   initial begin
      int         bad;
      logic [7:0] q5 [5];
      q5 = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
      u_if.tx_data = 8'h00;
      u_if.tx_ctrl = 8'h00;

      // Reset state, then 100 quiet cycles after release
      #12;
      check("rst_txd", u_if.txd, 1'b1);
      check("rst_status", u_if.status, ST_RST);
      #11 rst_n = 1'b1;
      tick();
      quiet(100, bad);
      check("idle_100", 64'(bad), 0);

      // Single byte A5: start one cycle after the push edge
      toggle(8'hA5);
      tick();
      check("a5_pre_txd", u_if.txd, 1'b1);
      check("a5_queued", u_if.status, {PE, 7'h10});
      tick();
      check("a5_start_status", u_if.status, {PE, 7'h05});
      capture(8'hA5, "a5");
      check("a5_end_status", u_if.status, ST_RST);
      check("a5_end_txd", u_if.txd, 1'b1);

      // Overflow: five pushes while busy, fifth dropped
      toggle(8'h5A);
      tick(2);
      check("5a_start", u_if.txd, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         toggle(8'(i));
         tick();
         if (i == 4) check("full_at_4", u_if.status[1], 1'b1);
      end
      check("ovf_status", u_if.status, {PE, 7'h4B});
      tick(TF - 5);
      check("5a_gap", u_if.txd, 1'b1);
      tick();
      for (int b = 1; b <= 4; b++) begin
         capture(8'(b), $sformatf("q%0d", b));
         check($sformatf("q%0d_gap", b), u_if.txd, 1'b1);
         if (b < 4) tick();
      end
      check("ovf_after_drain", u_if.status, {PE, 7'h0C});
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         if (u_if.txd !== 1'b1 || u_if.status[0] !== 1'b0) bad++;
         tick();
      end
      check("no_05_frame", 64'(bad), 0);

      // OVF clear on rising ctrl[1]
      u_if.tx_ctrl[1] = 1'b1;
      tick();
      check("ovf_clr", u_if.status[3], 1'b0);
      u_if.tx_ctrl[1] = 1'b0;
      tick();

      // Set and clear in the same cycle: set wins
      toggle(8'h11); tick();
      toggle(8'h22); tick();
      check("11_start", u_if.txd, 1'b0);
      toggle(8'h33); tick();
      toggle(8'h44); tick();
      toggle(8'h55); tick();
      check("full_busy", u_if.status, {PE, 7'h43});
      toggle(8'h66);
      u_if.tx_ctrl[1] = 1'b1;
      tick();
      check("ovf_set_wins", u_if.status[3], 1'b1);
      u_if.tx_ctrl[1] = 1'b0;
      tick();
      u_if.tx_ctrl[1] = 1'b1;
      tick();
      check("ovf_clr2", u_if.status[3], 1'b0);
      u_if.tx_ctrl[1] = 1'b0;
      tick();

      // Push into a full FIFO on the pop cycle: both accepted
      tick(TF - 7);
      check("stop_to_idle", u_if.status, {PE, 7'h42});
      check("idle_gap_txd", u_if.txd, 1'b1);
      toggle(8'h77);
      tick();
      check("pop_push_status", u_if.status, {PE, 7'h43});
      for (int i = 0; i < 5; i++) begin
         capture(q5[i], $sformatf("f%0d", i));
         check($sformatf("f%0d_gap", i), u_if.txd, 1'b1);
         if (i < 4) tick();
      end
      check("drain_status", u_if.status, ST_RST);

      // Asynchronous reset in the middle of a DATA bit
      toggle(8'h3C); tick();
      toggle(8'hAA); tick();
      toggle(8'hBB); tick();
      tick(9);
      check("3c_bit1", u_if.txd, 1'b0);
      check("3c_queued", u_if.status[6:4], 3'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_txd", u_if.txd, 1'b1);
      check("async_status", u_if.status, ST_RST);
      u_if.tx_ctrl = 8'h00;
      tog          = 1'b0;
      tick(3);
      #3 rst_n = 1'b1;
      tick();
      quiet(100, bad);
      check("no_frame_after_rst", 64'(bad), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
